// File: rtl/aes_sub_bytes.sv
// aes_sub_bytes: registered AES SubBytes / InvSubBytes over a 128-bit state.
// All 16 byte lanes are independent. Each lane has one GF(2^8) inverter
// (square-and-multiply chain computing x^254), plus the forward affine map.
// Build option: define AES_SUB_BYTES_INV_EN to compile in the inverse
// direction (A^-1 input mux and output bypass mux). Without it the block is
// forward-only and the inv input is ignored.
module aes_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    output logic [127:0] out_data
);

    // Affine constants: forward map adds 0x63, inverse map adds 0x05.
    localparam logic [7:0] C_AFF_FWD = 8'h63;
    localparam logic [7:0] C_AFF_INV = 8'h05;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2*x^4*...*x^128; maps 0 to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward affine map: b'i = bi ^ b(i+4) ^ b(i+5) ^ b(i+6) ^ b(i+7) ^ c_i.
    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                 ^ b[(i + 7) % 8] ^ C_AFF_FWD[i];
        end
        return r;
    endfunction

`ifdef AES_SUB_BYTES_INV_EN
    // Inverse affine map: b'i = b(i+2) ^ b(i+5) ^ b(i+7) ^ d_i.
    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ C_AFF_INV[i];
        end
        return r;
    endfunction
`else
    // Direction select has no effect in the forward-only build.
    logic w_unused_inv;
    assign w_unused_inv = inv ^ ^C_AFF_INV;
`endif

    logic [127:0] w_sub_data;
    logic         r_valid;
    logic [127:0] r_data;

    for (genvar k = 0; k < 16; k++) begin : g_lane
        logic [7:0] w_x;
        logic [7:0] w_inv_in;
        logic [7:0] w_inv_out;
        logic [7:0] w_sub;

        assign w_x = in_data[8*k +: 8];
`ifdef AES_SUB_BYTES_INV_EN
        // Inverter input: raw byte (forward) or A^-1 of it (inverse).
        assign w_inv_in  = inv ? aff_inv(w_x) : w_x;
        assign w_inv_out = gf_inv(w_inv_in);
        // Lane output: affine of inverse (forward) or inverse directly.
        assign w_sub     = inv ? w_inv_out : aff_fwd(w_inv_out);
`else
        assign w_inv_in  = w_x;
        assign w_inv_out = gf_inv(w_inv_in);
        assign w_sub     = aff_fwd(w_inv_out);
`endif
        assign w_sub_data[8*k +: 8] = w_sub;
    end

    // Output register: valid follows in_valid, data loads only on valid transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 128'h0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_data <= w_sub_data;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// tb_aes_sub_bytes: directed + randomized bench for aes_sub_bytes.
// Reference S-boxes are generated by walking the multiplicative group with
// generator 3 (p *= 3, q /= 3), then the inverse table by inversion of the map.
module tb_aes_sub_bytes;

`ifdef AES_SUB_BYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    // clock / reset
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         inv;
    logic [127:0] in_data;
    logic         out_valid;
    logic [127:0] out_data;

    always #5 clk = ~clk;

    aes_sub_bytes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // scoreboard state
    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] exp_q[$];
    logic         exp_valid;
    logic [127:0] exp_data;
    int           checks   = 0;
    int           failures = 0;

    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic i);
        logic [127:0] r;
        r = 128'h0;
        for (int k = 0; k < 16; k++) begin
            if (INV_EN && i) r[8*k +: 8] = inv_sbox[d[8*k +: 8]];
            else             r[8*k +: 8] = sbox[d[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic check_out(input string tag);
        checks++;
        assert (out_valid === exp_valid) else begin
            failures++;
            $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, exp_valid);
        end
        checks++;
        assert (out_data === exp_data) else begin
            failures++;
            $error("FAIL %s out_data got=%032h exp=%032h", tag, out_data, exp_data);
        end
    endtask

    // Driver: at the falling edge check the result of the previous step,
    // then queue this step's expectation and drive its inputs.
    task automatic step(input logic v, input logic i, input logic [127:0] d,
                        input bit use_exp, input logic [127:0] expd, input string tag);
        @(negedge clk);
        check_out(tag);
        exp_valid = v;
        if (v) begin
            exp_q.push_back(use_exp ? expd : model(d, i));
            exp_data = exp_q.pop_front();
        end
        in_valid = v;
        inv      = i;
        in_data  = d;
    endtask

    task automatic go(input logic v, input logic i, input logic [127:0] d, input string tag);
        step(v, i, d, 1'b0, 128'h0, tag);
    endtask

    logic [7:0]   bnd_fin  [4];
    logic [7:0]   bnd_fout [4];
    logic [7:0]   bnd_iin  [4];
    logic [7:0]   bnd_iout [4];
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] rnd;

    initial begin
        bnd_fin  = '{8'h00, 8'h01, 8'h53, 8'hff};
        bnd_fout = '{8'h63, 8'h7c, 8'hed, 8'h16};
        bnd_iin  = '{8'h63, 8'h00, 8'hed, 8'h16};
        bnd_iout = '{8'h00, 8'h52, 8'h53, 8'hff};
        build_tables();

        // reset
        rst_n = 1'b0; in_valid = 1'b0; inv = 1'b0; in_data = 128'h0;
        exp_valid = 1'b0; exp_data = 128'h0;
        repeat (3) @(negedge clk);
        check_out("reset");
        rst_n = 1'b1;

        // FIPS-197 vectors
        step(1'b1, 1'b0, FIPS_IN, 1'b1, FIPS_OUT, "fips_fwd");
        step(1'b1, 1'b1, FIPS_OUT, 1'b1, INV_EN ? FIPS_IN : model(FIPS_OUT, 1'b1), "fips_inv");
        step(1'b1, 1'b1, FIPS_IN, 1'b1, INV_EN ? model(FIPS_IN, 1'b1) : FIPS_OUT, "fips_inv1");

        // boundary bytes rotated through every lane position
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                d[8*k +: 8] = bnd_fin[(k + r) % 4];
                e[8*k +: 8] = bnd_fout[(k + r) % 4];
            end
            step(1'b1, 1'b0, d, 1'b1, e, "bnd_fwd");
        end
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                d[8*k +: 8] = bnd_iin[(k + r) % 4];
                e[8*k +: 8] = bnd_iout[(k + r) % 4];
            end
            step(1'b1, 1'b1, d, 1'b1, INV_EN ? e : model(d, 1'b1), "bnd_inv");
        end

        // exhaustive, back-to-back, inv toggling every cycle
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < 256; v++) begin
                go(1'b1, 1'(v) ^ 1'(pass), {16{8'(v)}}, "exhaustive");
            end
        end

        // idle: valid drops for 3 cycles with garbage on the data bus
        go(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "pre_idle");
        for (int k = 0; k < 3; k++) begin
            go(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, "idle");
        end
        go(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "idle_resume");
        go(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "post_idle");

        // randomized mixed stream
        for (int k = 0; k < 200; k++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            go(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd, "random");
        end

        // mid-stream asynchronous reset
        go(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "pre_reset");
        go(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "pre_reset2");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_data  = 128'h0;
        check_out("async_reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        go(1'b0, 1'b0, 128'h0, "after_reset");
        go(1'b1, 1'b0, FIPS_IN, "first_after_reset");
        go(1'b0, 1'b0, 128'h0, "drain");
        @(negedge clk);
        check_out("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
